// File: rtl/aurora_pkg.sv
// ============================================================================
// Module   : aurora_pkg
// Brief    : Shared Aurora 8B/10B K-character codes and TX symbol FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package aurora_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_7 = 8'hFC;

    typedef enum logic [0:0] {
        RUN = 1'b0,
        CC  = 1'b1
    } tx_sym_state_t;

endpackage

`default_nettype wire

// File: rtl/cc_scheduler.sv
// ============================================================================
// Module   : cc_scheduler
// Brief    : Free-running CC period counter and RUN/CC sequencer for the lane.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cc_scheduler
    import aurora_pkg::*;
#(
    parameter int CC_PERIOD = 5000,
    parameter int CC_LEN    = 6
) (
    input  logic clk,
    input  logic rst_n,
    output logic cc_active,
    output logic next_cc_active
);

    localparam int CNT_W = $clog2(CC_PERIOD);
    localparam int LEN_W = (CC_LEN > 1) ? $clog2(CC_LEN) : 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(CC_PERIOD - 1);
    localparam logic [LEN_W-1:0] c_LEN_MAX = LEN_W'(CC_LEN - 1);

    tx_sym_state_t      r_state;
    tx_sym_state_t      w_next_state;
    logic [CNT_W-1:0]   r_cc_cnt;
    logic [LEN_W-1:0]   r_len_cnt;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN:     if (r_cc_cnt == c_CNT_MAX) w_next_state = CC;
            CC:      if (r_len_cnt == c_LEN_MAX) w_next_state = RUN;
            default: w_next_state = RUN;
        endcase
    end

    // len_cnt is held at zero throughout RUN so every CC entry starts cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_cc_cnt  <= '0;
            r_len_cnt <= '0;
        end else begin
            r_state   <= w_next_state;
            r_cc_cnt  <= (r_cc_cnt == c_CNT_MAX) ? '0 : r_cc_cnt + 1'b1;
            r_len_cnt <= (r_state == CC) ? r_len_cnt + 1'b1 : '0;
        end
    end

    assign cc_active      = (r_state == CC);
    assign next_cc_active = (w_next_state == CC);

endmodule

`default_nettype wire

// File: rtl/tx_symbol_gen.sv
// ============================================================================
// Module   : tx_symbol_gen
// Brief    : Merges user data, idle requests and CC sequences into one
//            registered character per cycle for the 8B/10B encoder.
//            Optional idle-request checker: TX_SYMBOL_GEN_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tx_symbol_gen
    import aurora_pkg::*;
#(
    parameter int CC_PERIOD = 5000,
    parameter int CC_LEN    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_K,
    input  logic       send_A,
    input  logic       send_R,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic [7:0] tx_char,
    output logic       tx_char_is_k
`ifdef TX_SYMBOL_GEN_CHECK_EN
    ,
    output logic       idle_conflict
`endif
);

    logic       w_cc_active;
    logic       w_next_cc_active;
    logic       w_accept;
    logic [7:0] w_char;
    logic       w_is_k;

    cc_scheduler #(
        .CC_PERIOD (CC_PERIOD),
        .CC_LEN    (CC_LEN)
    ) u_cc_scheduler (
        .clk            (clk),
        .rst_n          (rst_n),
        .cc_active      (w_cc_active),
        .next_cc_active (w_next_cc_active)
    );

    assign w_accept = tx_data_valid & tx_data_ready;

    always_comb begin
        w_char = K28_5;
        w_is_k = 1'b1;
        if (w_cc_active) begin
            w_char = K28_7;
        end else if (w_accept) begin
            w_char = tx_data;
            w_is_k = 1'b0;
        end else if (send_A) begin
            w_char = K28_3;
        end else if (send_K) begin
            w_char = K28_5;
        end else if (send_R) begin
            w_char = K28_0;
        end
    end

    // ready tracks the next state so the source sees the CC gap on time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_char       <= K28_5;
            tx_char_is_k  <= 1'b1;
            tx_data_ready <= 1'b0;
        end else begin
            tx_char       <= w_char;
            tx_char_is_k  <= w_is_k;
            tx_data_ready <= ~w_next_cc_active;
        end
    end

`ifdef TX_SYMBOL_GEN_CHECK_EN
    logic w_multi_req;

    assign w_multi_req = (send_K & send_A) | (send_K & send_R) | (send_A & send_R);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_conflict <= 1'b0;
        end else if (w_multi_req && !w_cc_active) begin
            idle_conflict <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_tx_symbol_gen.sv
// ============================================================================
// Module   : tb_tx_symbol_gen
// Brief    : Directed scoreboard bench for tx_symbol_gen (CC_PERIOD=16, CC_LEN=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tx_symbol_gen;

    localparam int P = 16;
    localparam int L = 4;

    logic       clk;
    logic       rst_n;
    logic       send_K;
    logic       send_A;
    logic       send_R;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;
    logic [7:0] tx_char;
    logic       tx_char_is_k;
`ifdef TX_SYMBOL_GEN_CHECK_EN
    logic       idle_conflict;
    logic       exp_conf;
    logic       conf_pending;
`endif

    int         n_cmp;
    int         n_mis;
    int         k;
    logic [8:0] exp_q[$];

    tx_symbol_gen #(
        .CC_PERIOD (P),
        .CC_LEN    (L)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .send_K        (send_K),
        .send_A        (send_A),
        .send_R        (send_R),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .tx_char       (tx_char),
        .tx_char_is_k  (tx_char_is_k)
`ifdef TX_SYMBOL_GEN_CHECK_EN
        ,
        .idle_conflict (idle_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle k counts from reset release; CC occupies cycles P..P+L-1 of each period
    function automatic bit m_cc(input int c);
        return (c >= P) && (((c - P) % P) < L);
    endfunction

    function automatic bit m_ready(input int c);
        return (c >= 1) && !m_cc(c);
    endfunction

    task automatic check_cycle();
        logic [8:0] e;
        n_cmp++;
        assert (tx_data_ready === m_ready(k)) else begin
            n_mis++;
            $error("FAIL ready k=%0d observed=%b expected=%b", k, tx_data_ready, m_ready(k));
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_mis++;
            $error("FAIL scoreboard_empty k=%0d observed=0 expected=1 entries", k);
        end else begin
            e = exp_q.pop_front();
            assert ({tx_char_is_k, tx_char} === e) else begin
                n_mis++;
                $error("FAIL char k=%0d observed=%b/%h expected=%b/%h",
                       k, tx_char_is_k, tx_char, e[8], e[7:0]);
            end
        end
`ifdef TX_SYMBOL_GEN_CHECK_EN
        n_cmp++;
        assert (idle_conflict === exp_conf) else begin
            n_mis++;
            $error("FAIL idle_conflict k=%0d observed=%b expected=%b", k, idle_conflict, exp_conf);
        end
`endif
    endtask

    // called at negedge of cycle k: check, drive, predict cycle k+1, advance
    task automatic step(input logic v, input logic [7:0] d,
                        input logic sk, input logic sa, input logic sr);
        logic [8:0] e;
        check_cycle();
        tx_data_valid = v;
        tx_data       = d;
        send_K        = sk;
        send_A        = sa;
        send_R        = sr;
        if (m_cc(k))                e = {1'b1, 8'hFC};
        else if (v && m_ready(k))   e = {1'b0, d};
        else if (sa)                e = {1'b1, 8'h7C};
        else if (sk)                e = {1'b1, 8'hBC};
        else if (sr)                e = {1'b1, 8'h1C};
        else                        e = {1'b1, 8'hBC};
        exp_q.push_back(e);
`ifdef TX_SYMBOL_GEN_CHECK_EN
        conf_pending = !m_cc(k) && ((sk && sa) || (sk && sr) || (sa && sr));
`endif
        @(posedge clk);
        k++;
`ifdef TX_SYMBOL_GEN_CHECK_EN
        if (conf_pending) exp_conf = 1'b1;
`endif
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        assert ({tx_char_is_k, tx_char, tx_data_ready} === {1'b1, 8'hBC, 1'b0}) else begin
            n_mis++;
            $error("FAIL %s observed=%b/%h/%b expected=1/bc/0", tag, tx_char_is_k, tx_char, tx_data_ready);
        end
`ifdef TX_SYMBOL_GEN_CHECK_EN
        n_cmp++;
        assert (idle_conflict === 1'b0) else begin
            n_mis++;
            $error("FAIL %s_conflict observed=%b expected=0", tag, idle_conflict);
        end
`endif
    endtask

    task automatic release_reset();
        exp_q.delete();
        rst_n = 1'b1;
        k = 0;
        exp_q.push_back({1'b1, 8'hBC});
    endtask

    initial begin
        int b;
        int guard;
        n_cmp = 0;
        n_mis = 0;
        k = 0;
        rst_n = 1'b0;
        send_K = 1'b0;
        send_A = 1'b0;
        send_R = 1'b0;
        tx_data = 8'h00;
        tx_data_valid = 1'b0;
`ifdef TX_SYMBOL_GEN_CHECK_EN
        exp_conf = 1'b0;
        conf_pending = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        release_reset();

        // idle across two CC windows
        while (k < 40) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // idle requests, each followed by a quiet cycle
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // data wins over send_R
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // stream 00..0F straddling the CC window at cycles 64..67
        while (k < 56) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        b = 0;
        guard = 0;
        while (b < 16 && guard < 64) begin
            if (m_ready(k)) begin
                step(1'b1, 8'(b), 1'b0, 1'b0, 1'b0);
                b++;
            end else begin
                step(1'b1, 8'(b), 1'b0, 1'b0, 1'b0);
            end
            guard++;
        end
        n_cmp++;
        assert (b == 16) else begin
            n_mis++;
            $error("FAIL stream_count observed=%0d expected=16", b);
        end

        // asynchronous reset during the second CC character (cycle 82)
        while (k < 82) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
`ifdef TX_SYMBOL_GEN_CHECK_EN
        exp_conf = 1'b0;
`endif
        repeat (2) @(negedge clk);
        release_reset();
        while (k < 24) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef TX_SYMBOL_GEN_CHECK_EN
        // conflicting idle requests: A wins, sticky flag follows
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`endif
        check_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tx_symbol_gen.md
# tx_symbol_gen

Transmit-side lane symbol generator for the Aurora 8B/10B link. Sits directly downstream of the idle generator and upstream of the 8B/10B encoder. Each cycle it merges user data, the idle generator's send_K/send_A/send_R requests and periodic clock-compensation (CC) sequences into one registered 8-bit character plus a K-flag. It throttles user data with a ready signal while CC is being emitted.

## Interface
- CC_PERIOD, 5000: cycles between CC sequence starts; must be > CC_LEN + 1.
- CC_LEN, 6: number of K28.7 characters per CC sequence; must be ≥ 1.
- One clock; reset is asynchronous and active-low: clk and rst_n.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- send_K  in  1  idle request: emit K28.5
- send_A  in  1  idle request: emit K28.3
- send_R  in  1  idle request: emit K28.0
- tx_data  in  8  user data byte
- tx_data_valid  in  1  tx_data is valid
- tx_data_ready  out  1  registered; byte accepted when valid & ready
- tx_char  out  8  character to the 8B/10B encoder
- tx_char_is_k  out  1  tx_char is a control (K) character
- idle_conflict  out  1  sticky error; present only with the macro

## Operation
- Character codes: K28.5=8'hBC, K28.3=8'h7C, K28.0=8'h1C, K28.7=8'hFC.
- FSM states are RUN and CC. Reset state is RUN.
- cc_cnt: free-running counter, width $clog2(CC_PERIOD).
  - Resets to 0, increments every cycle, wraps CC_PERIOD-1 → 0.
  - Keeps counting in both states.
- RUN → CC when cc_cnt == CC_PERIOD-1.
- CC: len_cnt counts 0..CC_LEN-1. CC → RUN after the cycle with len_cnt == CC_LEN-1. len_cnt is cleared on entry.
- Character selection, evaluated in cycle N and registered at N+1, highest priority first:
  1. state CC → 8'hFC, is_k=1.
  2. tx_data_valid & tx_data_ready → tx_data, is_k=0.
  3. send_A → 8'h7C, is_k=1.
  4. send_K → 8'hBC, is_k=1.
  5. send_R → 8'h1C, is_k=1.
  6. Otherwise → 8'hBC, is_k=1 (safe comma).
- While data is being accepted, idle flags are ignored.
- The priority A > K > R applies only if the upstream block violates mutual exclusion.
- tx_data_ready is 1 exactly in cycles where state == RUN. It is registered from the next-state value.
- An unaccepted byte must be held stable by the source (valid/ready handshake). Valid without ready has no effect.

## Timing
- Latency: 1 cycle from inputs to tx_char/tx_char_is_k.
- Reset values: tx_char=8'hBC, tx_char_is_k=1, tx_data_ready=0, idle_conflict=0, cc_cnt=0, state=RUN.
- tx_data_ready goes to 1 at the first clk edge after rst_n deasserts.
- cc_cnt == CC_PERIOD-1 in cycle N:
  - tx_data_ready = 0 in cycles N+1..N+CC_LEN.
  - tx_char = 8'hFC in cycles N+2..N+CC_LEN+1.
- A byte presented in cycle N is still accepted in cycle N.
- Reset mid-CC aborts the sequence immediately (asynchronous). The next CC follows CC_PERIOD cycles after release.

## Configuration
- TX_SYMBOL_GEN_CHECK_EN defined:
  - Adds the idle_conflict port.
  - idle_conflict is set 1 cycle after any cycle with two or more of send_K/send_A/send_R high while in RUN.
  - It stays set until rst_n.
- TX_SYMBOL_GEN_CHECK_EN undefined: the port and its logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package aurora_pkg holds:
  - the K-character localparams (K28_5, K28_3, K28_0, K28_7);
  - the FSM enum tx_sym_state_t {RUN, CC}.
- One sub-module: cc_scheduler. It contains cc_cnt, len_cnt and the FSM, and outputs cc_active and next_cc_active. The top level keeps the character mux and output registers.

## Test plan
- Reset release, CC_PERIOD=16, CC_LEN=4, no inputs → tx_char=8'hBC, is_k=1, ready=1 from cycle 1. Ready low in cycles 16..19. 8'hFC appears in cycles 17..20.
- Valid=1 streaming bytes 8'h00..8'h0F → each byte appears at tx_char one cycle after acceptance with is_k=0. No byte is dropped or duplicated across the CC gap.
- send_A, send_K, send_R pulses with no data → 8'h7C, 8'hBC, 8'h1C respectively, one cycle later.
- Data valid together with send_R → data byte is output and send_R is ignored.
- rst_n asserted during the 2nd CC character → outputs return immediately to 8'hBC/1/ready=0. The next CC starts 16 cycles after release.
- With TX_SYMBOL_GEN_CHECK_EN, send_K & send_A high for one cycle → output is 8'h7C; idle_conflict rises next cycle and remains 1 until reset.
